ds_slot_scheduler: RTL and testbench
====================================

# ds_slot_scheduler

Time-division scheduler that shares the symbol output between three upstream byte streams. Each stream gets a fixed-length slot of symbols in round-robin order, and the set of active streams is selected by `mode`. The block sits between the stream sources and the line encoder. It runs on the system clock and advances once per symbol strobe. It adds per-stream valid/ready handshakes, idle-byte fill on underrun, glitch-free reconfiguration at frame boundaries, and underrun statistics.

## Interface
- `DATA_W`, 8, byte width of every stream.
- `SLOT_W`, 3, width of `slot_len`.
- `IDLE_BYTE`, 8'h00, byte emitted when the scheduled stream has no data.
- `clk`  in  1  system clock (100 MHz); all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sym_en`  in  1  one-`clk` strobe per symbol period, already synchronous to `clk`; may be high on consecutive cycles.
- `mode`  in  2  00 = off, 01 = DS1 only, 10 = DS1/DS2, 11 = DS1/DS2/DS3.
- `slot_len`  in  SLOT_W  symbols per slot; 0 is illegal.
- `dsN_data`  in  DATA_W  stream N data (N = 1..3).
- `dsN_valid`  in  1  stream N has a byte.
- `dsN_ready`  out  1  stream N byte consumed this cycle.
- `out_data`  out  DATA_W  scheduled symbol byte.
- `out_valid`  out  1  one-cycle pulse: `out_data` updated.
- `out_sel`  out  2  source of `out_data`: 1..3 for DSn, 0 for idle fill.
- `frame_start`  out  1  one-cycle pulse with the first symbol of each frame.
- `underrun_cnt`  out  16  saturating count of idle-filled symbols while running.
- `cfg_err`  out  1  sticky; set when `slot_len` = 0 is loaded.

## Operation
- **States**
  - IDLE: `act_mode` = 00.
  - RUN: `act_mode` ≠ 00.
- **Shadow configuration**
  - `act_mode` and `act_len` are the shadow configuration. Live `mode`/`slot_len` are never used directly by the datapath.
  - In IDLE, on `sym_en`: latch `mode`/`slot_len`. If `mode` ≠ 00, go to RUN with `cur` = 1 and `slot_cnt` = 0. No symbol is emitted on this strobe.
  - Loading `slot_len` = 0 sets `act_len` = 1 and sets `cfg_err`.
- **Per `sym_en` in RUN**
  - If `dsCUR_valid`: `dsCUR_ready` = 1 in this cycle. Next cycle `out_data` = `dsCUR_data` and `out_sel` = `cur`.
  - Otherwise: `out_data` = `IDLE_BYTE`, `out_sel` = 0, and `underrun_cnt` increments, saturating at 16'hFFFF.
  - `out_valid` pulses on every strobe.
  - `frame_start` pulses with the symbol when `cur` = 1 and `slot_cnt` = 0.
- **Slot advance**
  - If `slot_cnt` = `act_len`−1: `slot_cnt` → 0 and `cur` → next active stream. Order is 1→2→3→1, truncated to the active set by `act_mode`.
  - Otherwise `slot_cnt` increments.
- **Frame boundary** (the last symbol of the last active slot)
  - After emitting, reload `act_mode`/`act_len` from the inputs.
  - If the new mode is 00, go to IDLE.
  - Otherwise `cur` = 1 and `slot_cnt` = 0.
- **`dsN_ready` rule**
  - `dsN_ready` = `sym_en` & RUN & (`cur` == N), combinational from registered state.
  - At most one `ready` is high per cycle. A transfer occurs only in a cycle with `valid` & `ready`.
  - Sources must not make `valid` depend on `ready`.
- **Arithmetic**
  - `slot_cnt` is SLOT_W bits wide.
  - The comparison against `act_len`−1 is done at SLOT_W width; `act_len` ≥ 1 is guaranteed, so it never wraps.

## Timing
- **Reset values**
  - `out_data` = `IDLE_BYTE`.
  - `out_valid`, `frame_start`, `out_sel`, `underrun_cnt`, `cfg_err`, all `dsN_ready` = 0.
  - State IDLE, `cur` = 1, `slot_cnt` = 0.
- **Latency:** one `clk` from the `sym_en` cycle to `out_valid`/`out_data`/`out_sel`/`frame_start`. `out_data` and `out_sel` hold until the next update.
- **Back-to-back strobes:** `sym_en` every cycle gives one symbol per cycle with no bubbles.
- **`mode`/`slot_len` changes mid-frame:** ignored until the frame boundary. Changes while in IDLE take effect on the next `sym_en`.
- **`rst` mid-frame:** all outputs drop to their reset values immediately and asynchronously. No partial transfer occurs: `ready` is forced to 0 while `rst` is high. The first `sym_en` after release follows the IDLE load rule.
- **Underrun:** the slot timing is unaffected. An underrun never stretches a slot or skips to another stream.
- **Without `sym_en`:** every register holds its value except the single-cycle pulses, which return to 0.

## Test plan
- **Reset, then mode=11, slot_len=2, all valid, sym_en every 4 clks, DSn data = 8'hA0+n.**
  - Strobe 1 loads, with no `out_valid`.
  - Then `out_sel` = 1,1,2,2,3,3,1…, with `out_data` matching.
  - `frame_start` pulses on the first symbol of each 1,1 pair.
  - Exactly one `ready` per strobe.
- **Mode=10, slot_len=3, `ds2_valid` = 0 during its slot.**
  - Three symbols of `IDLE_BYTE` with `out_sel` = 0.
  - `underrun_cnt` = 3.
  - The DS1 slot resumes on schedule.
- **Running mode=11/slot_len=1; switch `mode` to 01 and `slot_len` to 4 at the DS2 symbol.**
  - The DS3 symbol is still emitted.
  - Then `out_sel` = 1 four times per frame, with `frame_start` every 4 symbols.
- **Set `mode` to 00 mid-frame.**
  - The frame completes, then the block goes to IDLE: no further `out_valid`, and all `ready` = 0.
- **`slot_len` = 0 with mode 01.**
  - `cfg_err` = 1, and a slot length of 1 is used.
- **Assert `rst` for one clk in the middle of the DS2 slot with `sym_en` high.**
  - `ds2_ready` = 0 and all outputs return to reset values.
  - Restart begins with DS1 after the load strobe.
- **Underrun saturation:** force `underrun_cnt` to 16'hFFFF, then cause an underrun symbol.
  - The count stays at 16'hFFFF.

Source files
------------

// File: rtl/ds_slot_scheduler_if.sv
// Stream and symbol-output bundle for ds_slot_scheduler.
// The scheduler uses the slave view. The sources and sink use the master view.
interface ds_slot_scheduler_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] ds1_data;
  logic [DATA_W-1:0] ds2_data;
  logic [DATA_W-1:0] ds3_data;
  logic              ds1_valid;
  logic              ds2_valid;
  logic              ds3_valid;
  logic              ds1_ready;
  logic              ds2_ready;
  logic              ds3_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [1:0]        out_sel;
  logic              frame_start;

  modport slave (
    input  ds1_data, ds2_data, ds3_data,
    input  ds1_valid, ds2_valid, ds3_valid,
    output ds1_ready, ds2_ready, ds3_ready,
    output out_data, out_valid, out_sel, frame_start
  );

  modport master (
    output ds1_data, ds2_data, ds3_data,
    output ds1_valid, ds2_valid, ds3_valid,
    input  ds1_ready, ds2_ready, ds3_ready,
    input  out_data, out_valid, out_sel, frame_start
  );
endinterface

// File: rtl/ds_slot_scheduler.sv
// Round-robin time-division scheduler for three byte streams.
// It advances once per sym_en strobe. The active configuration (mode, slot
// length) is shadowed and only reloaded at frame boundaries.
module ds_slot_scheduler #(
  parameter int                DATA_W    = 8,
  parameter int                SLOT_W    = 3,
  parameter logic [DATA_W-1:0] IDLE_BYTE = {DATA_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sym_en,
  input  logic [1:0]         mode,
  input  logic [SLOT_W-1:0]  slot_len,
  ds_slot_scheduler_if.slave bus,
  output logic [15:0]        underrun_cnt,
  output logic               cfg_err
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [1:0]          act_mode_reg, act_mode_next;
  logic [SLOT_W-1:0]   act_len_reg, act_len_next;
  logic [1:0]          cur_reg, cur_next;
  logic [SLOT_W-1:0]   slot_cnt_reg, slot_cnt_next;
  logic [DATA_W-1:0]   out_data_reg, out_data_next;
  logic                out_valid_reg, out_valid_next;
  logic [1:0]          out_sel_reg, out_sel_next;
  logic                frame_start_reg, frame_start_next;
  logic [15:0]         underrun_reg, underrun_next;
  logic                cfg_err_reg, cfg_err_next;

  logic [DATA_W-1:0]   src_data;
  logic                src_valid;
  logic [SLOT_W-1:0]   load_len;
  logic [SLOT_W-1:0]   act_len_m1;
  logic                slot_last;
  logic                frame_end;

  // A zero slot length is illegal and is replaced by a length of one.
  assign load_len   = (slot_len == '0) ? {{(SLOT_W-1){1'b0}}, 1'b1} : slot_len;
  // act_len is never 0, so this subtraction cannot wrap.
  assign act_len_m1 = act_len_reg - {{(SLOT_W-1){1'b0}}, 1'b1};
  assign slot_last  = (slot_cnt_reg == act_len_m1);
  // The last active stream number equals act_mode (01->1, 10->2, 11->3).
  assign frame_end  = slot_last && (cur_reg == act_mode_reg);

  // Select the data and valid of the stream that owns the current slot.
  always_comb begin
    src_data  = IDLE_BYTE;
    src_valid = 1'b0;
    case (cur_reg)
      2'd1: begin src_data = bus.ds1_data; src_valid = bus.ds1_valid; end
      2'd2: begin src_data = bus.ds2_data; src_valid = bus.ds2_valid; end
      2'd3: begin src_data = bus.ds3_data; src_valid = bus.ds3_valid; end
      default: begin src_data = IDLE_BYTE; src_valid = 1'b0; end
    endcase
  end

  // The handshake is a function of registered state and the strobe only.
  // It is forced low while reset is asserted, so no partial transfer occurs.
  assign bus.ds1_ready = sym_en & ~rst & (state_reg == RUN) & (cur_reg == 2'd1);
  assign bus.ds2_ready = sym_en & ~rst & (state_reg == RUN) & (cur_reg == 2'd2);
  assign bus.ds3_ready = sym_en & ~rst & (state_reg == RUN) & (cur_reg == 2'd3);

  assign bus.out_data    = out_data_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_sel     = out_sel_reg;
  assign bus.frame_start = frame_start_reg;
  assign underrun_cnt    = underrun_reg;
  assign cfg_err         = cfg_err_reg;

  // Next-state logic: configuration load, symbol emission and slot advance.
  always_comb begin
    state_next       = state_reg;
    act_mode_next    = act_mode_reg;
    act_len_next     = act_len_reg;
    cur_next         = cur_reg;
    slot_cnt_next    = slot_cnt_reg;
    out_data_next    = out_data_reg;
    out_sel_next     = out_sel_reg;
    out_valid_next   = 1'b0;
    frame_start_next = 1'b0;
    underrun_next    = underrun_reg;
    cfg_err_next     = cfg_err_reg;

    case (state_reg)
      IDLE: begin
        // Load strobe: latch the configuration. No symbol is emitted.
        if (sym_en) begin
          act_mode_next = mode;
          act_len_next  = load_len;
          if (slot_len == '0) cfg_err_next = 1'b1;
          if (mode != 2'b00) begin
            state_next    = RUN;
            cur_next      = 2'd1;
            slot_cnt_next = '0;
          end
        end
      end

      RUN: begin
        if (sym_en) begin
          out_valid_next   = 1'b1;
          frame_start_next = (cur_reg == 2'd1) && (slot_cnt_reg == '0);
          if (src_valid) begin
            out_data_next = src_data;
            out_sel_next  = cur_reg;
          end else begin
            // Underrun: fill with the idle byte and leave the slot timing unchanged.
            out_data_next = IDLE_BYTE;
            out_sel_next  = 2'd0;
            if (underrun_reg != 16'hFFFF) underrun_next = underrun_reg + 16'd1;
          end

          if (frame_end) begin
            // Frame boundary: this is the only point where a new configuration is applied.
            act_mode_next = mode;
            act_len_next  = load_len;
            if (slot_len == '0) cfg_err_next = 1'b1;
            if (mode == 2'b00) state_next = IDLE;
            cur_next      = 2'd1;
            slot_cnt_next = '0;
          end else if (slot_last) begin
            // The current stream is not the last active one, so the next stream is cur+1.
            slot_cnt_next = '0;
            cur_next      = cur_reg + 2'd1;
          end else begin
            slot_cnt_next = slot_cnt_reg + {{(SLOT_W-1){1'b0}}, 1'b1};
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      act_mode_reg    <= 2'b00;
      act_len_reg     <= {{(SLOT_W-1){1'b0}}, 1'b1};
      cur_reg         <= 2'd1;
      slot_cnt_reg    <= '0;
      out_data_reg    <= IDLE_BYTE;
      out_valid_reg   <= 1'b0;
      out_sel_reg     <= 2'd0;
      frame_start_reg <= 1'b0;
      underrun_reg    <= 16'd0;
      cfg_err_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      act_mode_reg    <= act_mode_next;
      act_len_reg     <= act_len_next;
      cur_reg         <= cur_next;
      slot_cnt_reg    <= slot_cnt_next;
      out_data_reg    <= out_data_next;
      out_valid_reg   <= out_valid_next;
      out_sel_reg     <= out_sel_next;
      frame_start_reg <= frame_start_next;
      underrun_reg    <= underrun_next;
      cfg_err_reg     <= cfg_err_next;
    end
  end

endmodule

// File: tb/tb_ds_slot_scheduler.sv
// Directed scoreboard bench for ds_slot_scheduler.
module tb_ds_slot_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        sym_en;
  logic [1:0]  mode;
  logic [2:0]  slot_len;
  logic [15:0] underrun_cnt;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    logic       fs;
  } exp_t;

  exp_t sb[$];

  ds_slot_scheduler_if #(.DATA_W(8)) bus ();

  ds_slot_scheduler #(
    .DATA_W(8),
    .SLOT_W(3),
    .IDLE_BYTE(8'h00)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sym_en       (sym_en),
    .mode         (mode),
    .slot_len     (slot_len),
    .bus          (bus),
    .underrun_cnt (underrun_cnt),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every emitted symbol must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_sel", 32'(bus.out_sel), 32'(e.sel));
        chk("out_data", 32'(bus.out_data), 32'(e.data));
        chk("frame_start", 32'(bus.frame_start), 32'(e.fs));
        $display("symbol: sel=%0d data=%02h fs=%0b underrun=%0d",
                 bus.out_sel, bus.out_data, bus.frame_start, underrun_cnt);
      end
    end
  end

  // One strobe: optionally expect a symbol, check the ready one-hot, then idle gap-1 cycles.
  task automatic strobe(input int gap, input logic emit, input logic [1:0] sel,
                        input logic [7:0] data, input logic fs, input int rdy);
    logic [2:0] rdy_exp;
    exp_t e;
    @(negedge clk);
    sym_en = 1'b1;
    if (emit) begin
      e.sel = sel; e.data = data; e.fs = fs;
      sb.push_back(e);
    end
    rdy_exp = (rdy == 0) ? 3'b000 : 3'(1 << (rdy - 1));
    #1;
    chk("ready_onehot", 32'({bus.ds3_ready, bus.ds2_ready, bus.ds1_ready}), 32'(rdy_exp));
    @(posedge clk);
    #1 sym_en = 1'b0;
    repeat (gap - 1) @(posedge clk);
  endtask

  function automatic logic [7:0] dsb(input int s);
    return 8'(8'hA0 + s);
  endfunction

  initial begin
    rst = 1'b1; sym_en = 1'b0; mode = 2'b00; slot_len = 3'd1;
    bus.ds1_data = 8'hA1; bus.ds2_data = 8'hA2; bus.ds3_data = 8'hA3;
    bus.ds1_valid = 1'b1; bus.ds2_valid = 1'b1; bus.ds3_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sel", 32'(bus.out_sel), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'h00);
    chk("rst_frame_start", 32'(bus.frame_start), 32'd0);
    chk("rst_underrun", 32'(underrun_cnt), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst = 1'b0;

    // Mode 11, slot 2, strobe every 4 clocks. Mid-frame config change is ignored.
    mode = 2'b11; slot_len = 3'd2;
    strobe(4, 1'b0, 2'd0, 8'h00, 1'b0, 0);
    for (int f = 0; f < 2; f++)
      for (int s = 1; s <= 3; s++)
        for (int k = 0; k < 2; k++) begin
          if (f == 1 && s == 1 && k == 0) begin mode = 2'b10; slot_len = 3'd3; end
          strobe(4, 1'b1, 2'(s), dsb(s), (s == 1 && k == 0), s);
        end

    // Mode 10, slot 3, DS2 underrun, back-to-back strobes.
    bus.ds2_valid = 1'b0;
    for (int k = 0; k < 3; k++) strobe(1, 1'b1, 2'd1, 8'hA1, (k == 0), 1);
    for (int k = 0; k < 3; k++) strobe(1, 1'b1, 2'd0, 8'h00, 1'b0, 2);
    chk("underrun_after_ds2_gap", 32'(underrun_cnt), 32'd3);
    bus.ds2_valid = 1'b1;
    for (int s = 1; s <= 2; s++)
      for (int k = 0; k < 3; k++) begin
        if (s == 2 && k == 0) begin mode = 2'b11; slot_len = 3'd1; end
        strobe(2, 1'b1, 2'(s), dsb(s), (s == 1 && k == 0), s);
      end

    // Mode 11, slot 1. Switch to 01/4 at the DS2 symbol; DS3 is still emitted.
    strobe(2, 1'b1, 2'd1, 8'hA1, 1'b1, 1);
    mode = 2'b01; slot_len = 3'd4;
    strobe(2, 1'b1, 2'd2, 8'hA2, 1'b0, 2);
    strobe(2, 1'b1, 2'd3, 8'hA3, 1'b0, 3);
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 4; k++) begin
        if (f == 1 && k == 1) mode = 2'b00;
        strobe(1, 1'b1, 2'd1, 8'hA1, (k == 0), 1);
      end

    // Now IDLE: strobes emit nothing and raise no ready.
    for (int k = 0; k < 3; k++) strobe(2, 1'b0, 2'd0, 8'h00, 1'b0, 0);

    // slot_len = 0 with mode 01 -> cfg_err, slot length of one.
    mode = 2'b01; slot_len = 3'd0;
    strobe(2, 1'b0, 2'd0, 8'h00, 1'b0, 0);
    chk("cfg_err_set", 32'(cfg_err), 32'd1);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin mode = 2'b11; slot_len = 3'd2; end
      strobe(2, 1'b1, 2'd1, 8'hA1, 1'b1, 1);
    end

    // Reset in the middle of the DS2 slot while sym_en is high.
    strobe(2, 1'b1, 2'd1, 8'hA1, 1'b1, 1);
    strobe(2, 1'b1, 2'd1, 8'hA1, 1'b0, 1);
    strobe(2, 1'b1, 2'd2, 8'hA2, 1'b0, 2);
    @(negedge clk);
    sym_en = 1'b1; rst = 1'b1;
    #1;
    chk("rst_mid_ds2_ready", 32'(bus.ds2_ready), 32'd0);
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_out_sel", 32'(bus.out_sel), 32'd0);
    chk("rst_mid_out_data", 32'(bus.out_data), 32'h00);
    chk("rst_mid_underrun", 32'(underrun_cnt), 32'd0);
    chk("rst_mid_cfg_err", 32'(cfg_err), 32'd0);
    @(negedge clk);
    rst = 1'b0; sym_en = 1'b0;
    strobe(2, 1'b0, 2'd0, 8'h00, 1'b0, 0);
    for (int s = 1; s <= 3; s++)
      for (int k = 0; k < 2; k++)
        strobe(2, 1'b1, 2'(s), dsb(s), (s == 1 && k == 0), s);

    // Underrun counter saturation.
    bus.ds1_valid = 1'b0;
    force dut.underrun_reg = 16'hFFFF;
    strobe(2, 1'b1, 2'd0, 8'h00, 1'b1, 1);
    release dut.underrun_reg;
    strobe(2, 1'b1, 2'd0, 8'h00, 1'b0, 1);
    chk("underrun_saturated", 32'(underrun_cnt), 32'h0000FFFF);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
